// File: rtl/trd_sched_pkg.sv
// Shared definitions for the thread scheduler: sizing, per-thread state
// encoding, write-back thread-control encodings and a RUN-vector helper.
package trd_sched_pkg;

   localparam int unsigned NUM_TRD = 8;
   localparam int unsigned TRD_W   = $clog2(NUM_TRD);

   typedef enum logic [1:0] {
      TRD_FREE  = 2'b00,
      TRD_RUN   = 2'b01,
      TRD_SLEEP = 2'b10
   } trd_state_t;

   // trd_ctrl field decoded in write-back into the individual pulses
   typedef enum logic [2:0] {
      CTRL_NONE  = 3'b000,
      CTRL_SLEEP = 3'b001,
      CTRL_WAKE  = 3'b010,
      CTRL_KILL  = 3'b011,
      CTRL_INIT  = 3'b111
   } trd_ctrl_t;

   // One bit per thread, set where the thread is RUN
   function automatic logic [NUM_TRD-1:0] run_vec(input trd_state_t [NUM_TRD-1:0] st);
      logic [NUM_TRD-1:0] v;
      v = '0;
      for (int i = 0; i < int'(NUM_TRD); i++) begin
         v[i] = (st[i] == TRD_RUN);
      end
      return v;
   endfunction

endpackage

// File: rtl/trd_sched_rr_arb.sv
// Rotate-priority encoder: finds the first set request bit searching
// last+1, last+2, ... last+N (mod N), so the previous grant is searched last.
//   req   : request vector, one bit per requester
//   last  : previous grant
//   gnt_c : next grant (equals last when nothing is requested)
//   vld_c : at least one request bit is set
module rr_arb #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 3
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [W-1:0] gnt_c,
   output logic         vld_c
);

   logic [W-1:0] idx_c;

   // Walk offsets from farthest to nearest so the nearest hit wins.
   // Offset N wraps to last itself because N is a power of two.
   always_comb begin
      gnt_c = last;
      vld_c = 1'b0;
      idx_c = '0;
      for (int unsigned i = N; i >= 1; i--) begin
         idx_c = W'(last + W'(i));
         if (req[idx_c]) begin
            gnt_c = idx_c;
            vld_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/trd_sched.sv
// Thread scheduler and state table, fed by the write-back control pulses.
//   clk, rst_n           : core clock, async active-low reset
//   kill/sleep/wake/init_wb : decoded write-back thread-control pulses
//   flushWB              : write-back instruction squashed, pulses ignored
//   trd_wb, tgt_trd      : issuing thread, wake target
//   stall_if             : fetch stalled, hold the current pick
//   new_trd              : lowest FREE thread (0 if none), combinational
//   fetch_trd, fetch_vld : registered round-robin fetch selection
//   flush_vld, flush_trd : registered one-cycle front-end flush request
//   trd_run              : registered per-thread RUN status
module trd_sched
   import trd_sched_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               kill,
   input  logic               sleep,
   input  logic               wake,
   input  logic               init_wb,
   input  logic               flushWB,
   input  logic [TRD_W-1:0]   trd_wb,
   input  logic [TRD_W-1:0]   tgt_trd,
   input  logic               stall_if,
   output logic [TRD_W-1:0]   new_trd,
   output logic [TRD_W-1:0]   fetch_trd,
   output logic               fetch_vld,
   output logic               flush_vld,
   output logic [TRD_W-1:0]   flush_trd,
   output logic [NUM_TRD-1:0] trd_run
);

   trd_state_t [NUM_TRD-1:0] state_q, state_d;
   logic [NUM_TRD-1:0]       wake_pend_q, wake_pend_d;
   logic [TRD_W-1:0]         fetch_trd_q, fetch_trd_d;
   logic                     fetch_vld_q, fetch_vld_d;
   logic                     flush_vld_q, flush_vld_d;
   logic [TRD_W-1:0]         flush_trd_q, flush_trd_d;
   logic [NUM_TRD-1:0]       trd_run_q, trd_run_d;

   logic [TRD_W-1:0]         new_trd_c;
   logic                     free_any_c;
   logic [NUM_TRD-1:0]       run_nxt_c;
   logic [TRD_W-1:0]         arb_gnt_c;
   logic                     arb_vld_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_TRD); i++) begin
            state_q[i] <= TRD_FREE;
         end
         state_q[0]  <= TRD_RUN;
         wake_pend_q <= '0;
         fetch_trd_q <= '0;
         fetch_vld_q <= 1'b1;
         flush_vld_q <= 1'b0;
         flush_trd_q <= '0;
         trd_run_q   <= NUM_TRD'(1);
      end else begin
         state_q     <= state_d;
         wake_pend_q <= wake_pend_d;
         fetch_trd_q <= fetch_trd_d;
         fetch_vld_q <= fetch_vld_d;
         flush_vld_q <= flush_vld_d;
         flush_trd_q <= flush_trd_d;
         trd_run_q   <= trd_run_d;
      end
   end

   // Lowest-index FREE thread from registered state; 0 doubles as failure
   always_comb begin
      new_trd_c  = '0;
      free_any_c = 1'b0;
      for (int i = int'(NUM_TRD) - 1; i >= 0; i--) begin
         if (state_q[i] == TRD_FREE) begin
            new_trd_c  = TRD_W'(i);
            free_any_c = 1'b1;
         end
      end
   end

   // Next-state: thread table updates from write-back events
   always_comb begin
      state_d     = state_q;
      wake_pend_d = wake_pend_q;
      flush_vld_d = 1'b0;
      flush_trd_d = flush_trd_q;
      if (!flushWB) begin
         if (kill) begin
            // Thread 0 is the permanent root thread
            if (trd_wb != '0) begin
               state_d[trd_wb]     = TRD_FREE;
               wake_pend_d[trd_wb] = 1'b0;
               flush_vld_d         = 1'b1;
               flush_trd_d         = trd_wb;
            end
         end else if (sleep) begin
            // A wake that arrived while running cancels this sleep
            if (wake_pend_q[trd_wb]) begin
               wake_pend_d[trd_wb] = 1'b0;
            end else begin
               state_d[trd_wb] = TRD_SLEEP;
               flush_vld_d     = 1'b1;
               flush_trd_d     = trd_wb;
            end
         end else if (wake) begin
            case (state_q[tgt_trd])
               TRD_SLEEP: state_d[tgt_trd]     = TRD_RUN;
               TRD_RUN:   wake_pend_d[tgt_trd] = 1'b1;
               default:   ;
            endcase
         end else if (init_wb) begin
            if (free_any_c) begin
               state_d[new_trd_c] = TRD_RUN;
            end
         end
      end
   end

   // Scheduling looks at next-state so a thread leaving RUN is never picked
   assign run_nxt_c = run_vec(state_d);

   rr_arb #(
      .N (NUM_TRD),
      .W (TRD_W)
   ) u_rr_arb (
      .req   (run_nxt_c),
      .last  (fetch_trd_q),
      .gnt_c (arb_gnt_c),
      .vld_c (arb_vld_c)
   );

   // Output next-values: fetch selection and RUN status
   always_comb begin
      trd_run_d   = run_nxt_c;
      fetch_trd_d = fetch_trd_q;
      fetch_vld_d = 1'b0;
      if (stall_if) begin
         fetch_vld_d = run_nxt_c[fetch_trd_q];
      end else if (arb_vld_c) begin
         fetch_trd_d = arb_gnt_c;
         fetch_vld_d = 1'b1;
      end
   end

   assign new_trd   = new_trd_c;
   assign fetch_trd = fetch_trd_q;
   assign fetch_vld = fetch_vld_q;
   assign flush_vld = flush_vld_q;
   assign flush_trd = flush_trd_q;
   assign trd_run   = trd_run_q;

endmodule

// File: tb/tb_trd_sched.sv
// Scoreboard bench for trd_sched: directed write-back events with
// hand-computed expected outputs queued per cycle and checked by a monitor.
module tb_trd_sched;
   import trd_sched_pkg::*;

   logic             clk;
   logic             rst_n;
   logic             kill, sleep, wake, init_wb, flushWB, stall_if;
   logic [TRD_W-1:0] trd_wb, tgt_trd;
   logic [TRD_W-1:0] new_trd, fetch_trd, flush_trd;
   logic             fetch_vld, flush_vld;
   logic [NUM_TRD-1:0] trd_run;

   typedef struct {
      int             id;
      logic [2:0]     ftrd;
      logic           fvld;
      logic           flv;
      logic [2:0]     fltrd;
      logic [7:0]     run;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   trd_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .kill      (kill),
      .sleep     (sleep),
      .wake      (wake),
      .init_wb   (init_wb),
      .flushWB   (flushWB),
      .trd_wb    (trd_wb),
      .tgt_trd   (tgt_trd),
      .stall_if  (stall_if),
      .new_trd   (new_trd),
      .fetch_trd (fetch_trd),
      .fetch_vld (fetch_vld),
      .flush_vld (flush_vld),
      .flush_trd (flush_trd),
      .trd_run   (trd_run)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s step %0d: got %0h want %0h", nm, id, act, want);
      end
   endtask

   // Monitor: outputs update every edge, so one expectation per edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("fetch_trd", mon_e.id, 32'(fetch_trd), 32'(mon_e.ftrd));
         chk("fetch_vld", mon_e.id, 32'(fetch_vld), 32'(mon_e.fvld));
         chk("flush_vld", mon_e.id, 32'(flush_vld), 32'(mon_e.flv));
         chk("trd_run",   mon_e.id, 32'(trd_run),   32'(mon_e.run));
         if (mon_e.flv) chk("flush_trd", mon_e.id, 32'(flush_trd), 32'(mon_e.fltrd));
      end
   end

   task automatic step(input int id, input logic [2:0] code, input logic fwb,
                       input int wb, input int tgt, input logic stall, input int e_new,
                       input int e_ftrd, input logic e_fvld, input logic e_flv,
                       input int e_fltrd, input logic [7:0] e_run);
      exp_t e;
      @(negedge clk);
      kill     = (code == CTRL_KILL);
      sleep    = (code == CTRL_SLEEP);
      wake     = (code == CTRL_WAKE);
      init_wb  = (code == CTRL_INIT);
      flushWB  = fwb;
      trd_wb   = TRD_W'(wb);
      tgt_trd  = TRD_W'(tgt);
      stall_if = stall;
      #1;
      if (e_new >= 0) chk("new_trd", id, 32'(new_trd), 32'(e_new));
      e.id    = id;
      e.ftrd  = 3'(e_ftrd);
      e.fvld  = e_fvld;
      e.flv   = e_flv;
      e.fltrd = 3'(e_fltrd);
      e.run   = e_run;
      exp_q.push_back(e);
      @(posedge clk);
   endtask

   task automatic chk_reset_vals(input int id);
      chk("rst_fetch_trd", id, 32'(fetch_trd), 32'(0));
      chk("rst_fetch_vld", id, 32'(fetch_vld), 32'(1));
      chk("rst_flush_vld", id, 32'(flush_vld), 32'(0));
      chk("rst_flush_trd", id, 32'(flush_trd), 32'(0));
      chk("rst_trd_run",   id, 32'(trd_run),   32'(8'h01));
      chk("rst_new_trd",   id, 32'(new_trd),   32'(1));
   endtask

   initial begin
      rst_n = 1'b1;
      {kill, sleep, wake, init_wb, flushWB, stall_if} = '0;
      trd_wb = '0;
      tgt_trd = '0;
      #2 rst_n = 1'b0;
      #1 chk_reset_vals(0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      //   id code        fwb wb tgt stl new ftrd vld flv fl run
      step( 1, CTRL_NONE,  0, 0, 0, 0,  1, 0, 1, 0, 0, 8'h01);
      step( 2, CTRL_NONE,  0, 0, 0, 0,  1, 0, 1, 0, 0, 8'h01);
      step( 3, CTRL_INIT,  0, 0, 0, 0,  1, 1, 1, 0, 0, 8'h03);
      step( 4, CTRL_INIT,  0, 0, 0, 0,  2, 2, 1, 0, 0, 8'h07);
      step( 5, CTRL_INIT,  0, 0, 0, 0,  3, 3, 1, 0, 0, 8'h0F);
      step( 6, CTRL_NONE,  0, 0, 0, 0,  4, 0, 1, 0, 0, 8'h0F);
      step( 7, CTRL_NONE,  0, 0, 0, 0, -1, 1, 1, 0, 0, 8'h0F);
      step( 8, CTRL_NONE,  0, 0, 0, 0, -1, 2, 1, 0, 0, 8'h0F);
      step( 9, CTRL_NONE,  0, 0, 0, 0, -1, 3, 1, 0, 0, 8'h0F);
      step(10, CTRL_NONE,  0, 0, 0, 0, -1, 0, 1, 0, 0, 8'h0F);
      // thread 2 sleeps, skipped, then woken by thread 0
      step(11, CTRL_SLEEP, 0, 2, 0, 0,  4, 1, 1, 1, 2, 8'h0B);
      step(12, CTRL_NONE,  0, 0, 0, 0, -1, 3, 1, 0, 0, 8'h0B);
      step(13, CTRL_NONE,  0, 0, 0, 0, -1, 0, 1, 0, 0, 8'h0B);
      step(14, CTRL_WAKE,  0, 0, 2, 0, -1, 1, 1, 0, 0, 8'h0F);
      step(15, CTRL_NONE,  0, 0, 0, 0, -1, 2, 1, 0, 0, 8'h0F);
      step(16, CTRL_NONE,  0, 0, 0, 0, -1, 3, 1, 0, 0, 8'h0F);
      step(17, CTRL_NONE,  0, 0, 0, 0, -1, 0, 1, 0, 0, 8'h0F);
      // wake of a running thread cancels its next sleep only
      step(18, CTRL_WAKE,  0, 0, 1, 0, -1, 1, 1, 0, 0, 8'h0F);
      step(19, CTRL_SLEEP, 0, 1, 0, 0, -1, 2, 1, 0, 0, 8'h0F);
      step(20, CTRL_SLEEP, 0, 1, 0, 0, -1, 3, 1, 1, 1, 8'h0D);
      step(21, CTRL_WAKE,  0, 0, 1, 0, -1, 0, 1, 0, 0, 8'h0F);
      // fill all threads, allocation failure, kill rules
      step(22, CTRL_INIT,  0, 0, 0, 0,  4, 1, 1, 0, 0, 8'h1F);
      step(23, CTRL_INIT,  0, 0, 0, 0,  5, 2, 1, 0, 0, 8'h3F);
      step(24, CTRL_INIT,  0, 0, 0, 0,  6, 3, 1, 0, 0, 8'h7F);
      step(25, CTRL_INIT,  0, 0, 0, 0,  7, 4, 1, 0, 0, 8'hFF);
      step(26, CTRL_INIT,  0, 0, 0, 0,  0, 5, 1, 0, 0, 8'hFF);
      step(27, CTRL_KILL,  0, 0, 0, 0,  0, 6, 1, 0, 0, 8'hFF);
      step(28, CTRL_KILL,  0, 5, 0, 0,  0, 7, 1, 1, 5, 8'hDF);
      step(29, CTRL_NONE,  0, 0, 0, 0,  5, 0, 1, 0, 0, 8'hDF);
      // squashed events are ignored
      step(30, CTRL_KILL,  1, 3, 0, 0,  5, 1, 1, 0, 0, 8'hDF);
      step(31, CTRL_INIT,  1, 0, 0, 0,  5, 2, 1, 0, 0, 8'hDF);
      step(32, CTRL_SLEEP, 1, 2, 0, 0,  5, 3, 1, 0, 0, 8'hDF);
      // stall holds the pick; held thread sleeping drops fetch_vld
      step(33, CTRL_NONE,  0, 0, 0, 1, -1, 3, 1, 0, 0, 8'hDF);
      step(34, CTRL_SLEEP, 0, 3, 0, 1,  5, 3, 0, 1, 3, 8'hD7);
      step(35, CTRL_NONE,  0, 0, 0, 1,  5, 3, 0, 0, 0, 8'hD7);
      step(36, CTRL_NONE,  0, 0, 0, 0, -1, 4, 1, 0, 0, 8'hD7);
      step(37, CTRL_NONE,  0, 0, 0, 0, -1, 6, 1, 0, 0, 8'hD7);
      step(38, CTRL_NONE,  0, 0, 0, 0, -1, 7, 1, 0, 0, 8'hD7);

      // asynchronous reset mid-rotation, away from any clock edge
      @(negedge clk);
      {kill, sleep, wake, init_wb, flushWB, stall_if} = '0;
      rst_n = 1'b0;
      #1 chk_reset_vals(100);
      @(negedge clk);
      rst_n = 1'b1;

      step(39, CTRL_NONE,  0, 0, 0, 0,  1, 0, 1, 0, 0, 8'h01);
      step(40, CTRL_INIT,  0, 0, 0, 0,  1, 1, 1, 0, 0, 8'h03);

      @(negedge clk);
      {kill, sleep, wake, init_wb, flushWB, stall_if} = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("drain", 0, 32'(exp_q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/trd_sched.md
# trd_sched

Thread scheduler and state table. It sits directly downstream of the write-back stage and consumes its decoded thread-control pulses (`kill`, `sleep`, `wake`, `init_wb`). It returns the allocated thread ID (`new_trd`) that write-back places in the destination register. It also drives the round-robin thread selection for fetch and emits per-thread flush requests.

## Interface
- `NUM_TRD`, 8: number of hardware threads; must be a power of 2.
- `TRD_W`, 3: thread ID width, equal to log2(`NUM_TRD`).

- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `kill` in 1: from WB; the issuing thread terminates.
- `sleep` in 1: from WB; the issuing thread sleeps.
- `wake` in 1: from WB; wakes thread `tgt_trd`.
- `init_wb` in 1: from WB; allocates and starts a new thread.
- `flushWB` in 1: the WB instruction is squashed; all four control pulses are ignored.
- `trd_wb` in TRD_W: thread ID of the instruction in WB.
- `tgt_trd` in TRD_W: target of `wake`, taken from the low bits of the WB operand.
- `stall_if` in 1: fetch stalled; the scheduler holds its pick.
- `new_trd` out TRD_W: lowest-index FREE thread, or 0 if none is free. Combinational from state.
- `fetch_trd` out TRD_W: thread selected for fetch. Registered.
- `fetch_vld` out 1: `fetch_trd` is RUN. Registered.
- `flush_vld` out 1: one-cycle pulse requesting a flush of `flush_trd` in the front end. Registered.
- `flush_trd` out TRD_W: thread to flush.
- `trd_run` out NUM_TRD: one-hot-per-thread RUN status. Registered.

## Operation
- Each thread holds a 2-bit state: FREE=00, RUN=01, SLEEP=10. Each thread also holds a `wake_pend` bit.
- Reset values:
  - Thread 0 is RUN; all other threads are FREE.
  - All `wake_pend` bits are 0.
  - `fetch_trd`=0, `fetch_vld`=1, `flush_vld`=0, `flush_trd`=0, `trd_run`=8'h01.
- Event handling applies only when `flushWB`=0. At most one event is active per cycle because all four come from a single decoded field.
- **kill**
  - Thread `trd_wb` goes to FREE, its `wake_pend` clears, and a flush pulse is issued.
  - Thread 0 is never killed: the kill is ignored and no flush is issued.
- **sleep**
  - If `wake_pend[trd_wb]`=1: clear the bit; the thread stays RUN; no flush.
  - Otherwise: the thread goes to SLEEP and a flush pulse is issued.
- **wake**
  - If `tgt_trd` is SLEEP: it goes to RUN.
  - If `tgt_trd` is RUN: set `wake_pend[tgt_trd]`. This prevents a lost wake-up.
  - If `tgt_trd` is FREE: no effect.
- **init_wb**
  - If a FREE thread exists, thread `new_trd` goes to RUN.
  - If none exists, nothing changes. WB writes 0, which software reads as allocation failure.
- Scheduler:
  - Computed from the *next* state vector, so a thread being slept or killed this cycle is never picked.
  - When `stall_if`=0: `fetch_trd` takes the first RUN thread searching `fetch_trd`+1, +2, … +NUM_TRD (wrapping mod NUM_TRD; the current thread is searched last).
  - When `stall_if`=1: `fetch_trd` holds. If the held thread leaves RUN, `fetch_vld` drops to 0.
  - If no thread is RUN: `fetch_vld`=0 and `fetch_trd` holds.
- `trd_run` reflects the registered state.

## Timing
- A WB event at edge N updates the state, `trd_run`, `flush_vld`/`flush_trd`, and `fetch_trd`/`fetch_vld` at edge N+1. Latency is one cycle.
- `new_trd` is combinational from registered state. WB therefore captures the ID in the same cycle that `init_wb` is asserted, and that thread is RUN the next cycle.
- `flush_vld` is high for exactly one cycle per accepted kill or effective sleep.
- Reset is asynchronous. Asserting `rst_n` mid-operation returns all state to the reset values immediately, independent of `clk`.

## Structure
- A shared package holds `NUM_TRD`, `TRD_W`, the `trd_state_t` enum (FREE/RUN/SLEEP), and the trd_ctrl encodings (001 sleep, 010 wake, 011 kill, 111 init).
- One sub-module, `rr_arb`: a parameterized rotate-priority-encoder taking the request vector and last grant, and producing the next grant plus a valid signal.

## Test plan
- Reset, no events → `fetch_trd` cycles 0,0,0…; `trd_run`=8'h01; `new_trd`=1.
- `init_wb` from thread 0 three times → `new_trd` reads 1, 2, 3 on successive events; `trd_run`=8'h0F; fetch rotates 0→1→2→3→0.
- Thread 2 `sleep` → flush pulse with `flush_trd`=2; thread 2 is skipped in rotation. Thread 0 then issues `wake` with `tgt_trd`=2 → thread 2 is back in rotation one cycle later.
- `wake` with `tgt_trd`=1 while thread 1 is RUN, then thread 1 `sleep` → no flush; thread 1 stays RUN; `wake_pend[1]` clears.
- All 8 threads RUN, then `init_wb` → `new_trd`=0 and no state change. Then `kill` from thread 0 → ignored. Then `kill` from thread 5 → `new_trd`=5.
- Events with `flushWB`=1 → ignored. `stall_if`=1 during a sleep of the held thread → `fetch_vld`=0. Asserting `rst_n` mid-rotation → reset values immediately.
